dfm_spi_master: RTL and testbench
=================================

# dfm_spi_master

Host-side SPI master for the digital frequency meter: it drives the other end of the meter's SPI slave and D/C line. A host issues a command byte and a read length; the block runs one chip-select-framed SPI mode-0 transaction, shifts out the command, then clocks out up to 8 dummy bytes. Each byte the meter returns on MISO is delivered as a single-cycle valid strobe. It sits in the test or host FPGA between host control logic and the meter's `spi_*` and `dc_i` pins.

## Interface
- `CLK_DIV`, 4: clk_i cycles per SCLK half-period; must be ≥1.
- `CS_SETUP`, 2: cycles CS_n is low before the first SCLK rising edge; must be ≥1.
- `CS_HOLD`, 2: cycles CS_n stays low after the last SCLK falling edge; must be ≥1.
- `clk_i` in 1: the single clock; all logic is on its rising edge.
- `rst_i` in 1: synchronous reset, active-high.
- `cmd_vld_i` in 1: transaction request.
- `cmd_rdy_o` out 1: block is idle and can accept a request.
- `cmd_dc_i` in 1: D/C level for the transaction.
- `cmd_data_i` in 8: command byte.
- `rd_len_i` in 4: number of bytes to read after the command, 0..8. Values above 8 are clamped to 8.
- `rd_vld_o` out 1: one-cycle strobe; a received byte is valid.
- `rd_data_o` out 8: the received byte.
- `done_o` out 1: one-cycle strobe at the end of a transaction.
- `spi_sclk_o`, `spi_mosi_o`, `spi_cs_n_o`, `dc_o` out 1 each: SPI and D/C pins.
- `spi_miso_i` in 1: MISO from the meter, already synchronised by the instantiating logic.

## Operation
- The FSM has four states: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE:
  - `cmd_rdy_o`=1.
  - A request is accepted on an edge where `cmd_vld_i & cmd_rdy_o`.
  - On acceptance the block latches `cmd_dc_i`, `cmd_data_i` and `min(rd_len_i,8)`.
  - In that same edge it drives CS_n=0, `dc_o`=latched D/C and MOSI=`cmd_data_i[7]`, and enters SETUP.
- SETUP: lasts CS_SETUP cycles with SCLK=0, then enters XFER.
- XFER:
  - Sends 1+rd_len bytes MSB-first in mode 0 (CPOL=0, CPHA=0).
  - Each bit is CLK_DIV cycles with SCLK low followed by CLK_DIV cycles with SCLK high.
  - MISO is shifted into the receive register on the clk edge that drives SCLK 0→1.
  - MOSI changes to the next bit on the clk edge that drives SCLK 1→0.
  - Byte 0 is the command byte. Bytes 1..rd_len transmit 0x00.
  - The data received during byte 0 is discarded. No `rd_vld_o` is produced for it.
  - For bytes 1..rd_len: `rd_vld_o`=1 and `rd_data_o`=the assembled byte, for exactly one cycle, on the cycle after the edge that samples that byte's bit 0.
  - After the final SCLK falling edge the block enters HOLD.
- HOLD: lasts CS_HOLD cycles with SCLK=0 and CS_n=0. Then CS_n=1, `dc_o`=0, `done_o` pulses for one cycle, and the block returns to IDLE.
- `cmd_rdy_o`=0 from the acceptance edge until the return to IDLE.
  - `cmd_vld_i` is ignored while busy.
  - Back-to-back requests give at least 1 cycle of CS_n high between transactions.
- Counters:
  - Divide counter ⌈log2 CLK_DIV⌉ bits.
  - 3-bit bit counter; wraps 7→0 per byte.
  - 4-bit byte counter, 0..8.
  - None of them wrap past their terminal count.

## Timing
- Reset values:
  - `spi_cs_n_o`=1, `spi_sclk_o`=0, `spi_mosi_o`=0, `dc_o`=0.
  - `cmd_rdy_o`=1, `rd_vld_o`=0, `rd_data_o`=0, `done_o`=0.
  - State=IDLE.
- `rst_i` in mid-transaction: all outputs return to their reset values on that edge. The partial byte is dropped, and no `rd_vld_o` or `done_o` is produced.
- CS_n low duration: CS_SETUP + (1+rd_len)·16·CLK_DIV + CS_HOLD cycles. With the defaults and rd_len=8 this is 580 cycles.
- `done_o` is asserted on the same edge that raises CS_n.
- `rd_vld_o` for the last byte precedes `done_o` by CLK_DIV+CS_HOLD cycles.
- `dc_o` is stable from CS_n falling until CS_n rising.

## Test plan
- Command only: cmd 0x2A, dc=1, rd_len=0, CLK_DIV=4.
  - MOSI shows 00101010 across 8 SCLK rises.
  - CS_n is low for 2+64+2 cycles.
  - One `done_o`, no `rd_vld_o`.
- Read 8 bytes: cmd 0x01, rd_len=8, MISO model returns 0x11,0x22,…,0x88 after the command byte.
  - Eight `rd_vld_o` pulses with exactly those values, in order.
  - MOSI is 0 during every read byte.
- Clamp: rd_len=15.
  - Exactly 8 read bytes.
  - CS_n is low for 580 cycles.
- Busy: hold `cmd_vld_i`=1 with a second request during a transaction.
  - `cmd_rdy_o`=0 until IDLE.
  - The second transaction starts one cycle after `done_o`, with CS_n high for ≥1 cycle in between.
- Reset mid-byte: assert `rst_i` at the 3rd SCLK rise of read byte 2.
  - Next edge: CS_n=1, SCLK=0, `cmd_rdy_o`=1.
  - No further `rd_vld_o` and no `done_o`.
- CLK_DIV=1:
  - SCLK toggles every cycle.
  - MISO pattern 0xA5 is captured correctly.
  - MOSI changes only on SCLK falling edges.

Source files
------------

// File: rtl/dfm_spi_master_if.sv
// Host request/response bundle of the frequency-meter SPI master: command
// handshake, read-length, received-byte strobe and end-of-transaction strobe.
interface dfm_spi_master_if;
    logic       cmd_vld_i;
    logic       cmd_rdy_o;
    logic       cmd_dc_i;
    logic [7:0] cmd_data_i;
    logic [3:0] rd_len_i;
    logic       rd_vld_o;
    logic [7:0] rd_data_o;
    logic       done_o;

    modport master (
        output cmd_vld_i,
        output cmd_dc_i,
        output cmd_data_i,
        output rd_len_i,
        input  cmd_rdy_o,
        input  rd_vld_o,
        input  rd_data_o,
        input  done_o
    );

    modport slave (
        input  cmd_vld_i,
        input  cmd_dc_i,
        input  cmd_data_i,
        input  rd_len_i,
        output cmd_rdy_o,
        output rd_vld_o,
        output rd_data_o,
        output done_o
    );
endinterface

// File: rtl/dfm_spi_master.sv
// Host-side SPI mode-0 master for the frequency meter: one CS-framed burst of
// a command byte followed by up to eight dummy bytes whose replies are strobed out.
module dfm_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dfm_spi_master_if.slave host,
    output logic            spi_sclk_o,
    output logic            spi_mosi_o,
    output logic            spi_cs_n_o,
    output logic            dc_o,
    input  logic            spi_miso_i
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GRD_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int GRD_W   = (GRD_MAX > 1) ? $clog2(GRD_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [GRD_W-1:0] SETUP_LAST = GRD_W'(CS_SETUP - 1);
    localparam logic [GRD_W-1:0] HOLD_LAST  = GRD_W'(CS_HOLD - 1);
    localparam logic [3:0]       MAX_LEN    = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [GRD_W-1:0] r_grd_cnt;
    logic [2:0]       r_bit_cnt;
    logic [3:0]       r_byte_cnt;
    logic [3:0]       r_len;
    logic [6:0]       r_tx;
    logic [6:0]       r_rx;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_cs_n;
    logic             r_dc;
    logic             r_cmd_rdy;
    logic             r_rd_vld;
    logic [7:0]       r_rd_data;
    logic             r_done;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_div_cnt_nxt;
    logic [GRD_W-1:0] w_grd_cnt_nxt;
    logic [2:0]       w_bit_cnt_nxt;
    logic [3:0]       w_byte_cnt_nxt;
    logic [3:0]       w_len_nxt;
    logic [6:0]       w_tx_nxt;
    logic [6:0]       w_rx_nxt;
    logic             w_sclk_nxt;
    logic             w_mosi_nxt;
    logic             w_cs_n_nxt;
    logic             w_dc_nxt;
    logic             w_cmd_rdy_nxt;
    logic             w_rd_vld_nxt;
    logic [7:0]       w_rd_data_nxt;
    logic             w_done_nxt;

    logic             w_accept;
    logic             w_half_end;
    logic             w_last_bit;
    logic             w_last_byte;
    logic             w_setup_end;
    logic             w_hold_end;
    logic [3:0]       w_len_clamp;

    assign w_accept    = host.cmd_vld_i & r_cmd_rdy;
    assign w_half_end  = (r_div_cnt == DIV_LAST);
    assign w_last_bit  = (r_bit_cnt == 3'd7);
    assign w_last_byte = (r_byte_cnt == r_len);
    assign w_setup_end = (r_grd_cnt == SETUP_LAST);
    assign w_hold_end  = (r_grd_cnt == HOLD_LAST);
    assign w_len_clamp = (host.rd_len_i > MAX_LEN) ? MAX_LEN : host.rd_len_i;

    assign spi_sclk_o     = r_sclk;
    assign spi_mosi_o     = r_mosi;
    assign spi_cs_n_o     = r_cs_n;
    assign dc_o           = r_dc;
    assign host.cmd_rdy_o = r_cmd_rdy;
    assign host.rd_vld_o  = r_rd_vld;
    assign host.rd_data_o = r_rd_data;
    assign host.done_o    = r_done;

    // State and datapath register bank with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_grd_cnt  <= '0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 4'd0;
            r_len      <= 4'd0;
            r_tx       <= 7'd0;
            r_rx       <= 7'd0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_dc       <= 1'b0;
            r_cmd_rdy  <= 1'b1;
            r_rd_vld   <= 1'b0;
            r_rd_data  <= 8'h00;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_grd_cnt  <= w_grd_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_len      <= w_len_nxt;
            r_tx       <= w_tx_nxt;
            r_rx       <= w_rx_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_dc       <= w_dc_nxt;
            r_cmd_rdy  <= w_cmd_rdy_nxt;
            r_rd_vld   <= w_rd_vld_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state selection for the IDLE/SETUP/XFER/HOLD sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (w_setup_end) begin
                    w_state_nxt = ST_XFER;
                end else begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_XFER: begin
                if (w_half_end && r_sclk && w_last_bit && w_last_byte) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_HOLD: begin
                if (w_hold_end) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of pins, counters and shift registers for each state
    always_comb begin
        w_div_cnt_nxt  = r_div_cnt;
        w_grd_cnt_nxt  = r_grd_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_len_nxt      = r_len;
        w_tx_nxt       = r_tx;
        w_rx_nxt       = r_rx;
        w_sclk_nxt     = r_sclk;
        w_mosi_nxt     = r_mosi;
        w_cs_n_nxt     = r_cs_n;
        w_dc_nxt       = r_dc;
        w_cmd_rdy_nxt  = r_cmd_rdy;
        w_rd_vld_nxt   = 1'b0;
        w_rd_data_nxt  = r_rd_data;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cs_n_nxt     = 1'b0;
                    w_dc_nxt       = host.cmd_dc_i;
                    w_mosi_nxt     = host.cmd_data_i[7];
                    w_tx_nxt       = host.cmd_data_i[6:0];
                    w_len_nxt      = w_len_clamp;
                    w_cmd_rdy_nxt  = 1'b0;
                    w_grd_cnt_nxt  = '0;
                    w_div_cnt_nxt  = '0;
                    w_bit_cnt_nxt  = 3'd0;
                    w_byte_cnt_nxt = 4'd0;
                    w_rx_nxt       = 7'd0;
                end else begin
                    w_cmd_rdy_nxt  = 1'b1;
                end
            end
            ST_SETUP: begin
                w_sclk_nxt = 1'b0;
                if (w_setup_end) begin
                    w_grd_cnt_nxt = '0;
                    w_div_cnt_nxt = '0;
                end else begin
                    w_grd_cnt_nxt = r_grd_cnt + GRD_W'(1'b1);
                end
            end
            ST_XFER: begin
                if (!w_half_end) begin
                    w_div_cnt_nxt = r_div_cnt + DIV_W'(1'b1);
                end else if (!r_sclk) begin
                    // Rising edge: capture MISO; the command byte's reply is never strobed
                    w_div_cnt_nxt = '0;
                    w_sclk_nxt    = 1'b1;
                    w_rx_nxt      = {r_rx[5:0], spi_miso_i};
                    if (w_last_bit && (r_byte_cnt != 4'd0)) begin
                        w_rd_vld_nxt  = 1'b1;
                        w_rd_data_nxt = {r_rx, spi_miso_i};
                    end else begin
                        w_rd_vld_nxt  = 1'b0;
                    end
                end else begin
                    w_div_cnt_nxt = '0;
                    w_sclk_nxt    = 1'b0;
                    w_tx_nxt      = {r_tx[5:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (w_last_bit && w_last_byte) begin
                        w_mosi_nxt    = 1'b0;
                        w_grd_cnt_nxt = '0;
                    end else if (w_last_bit) begin
                        w_mosi_nxt     = r_tx[6];
                        w_byte_cnt_nxt = r_byte_cnt + 4'd1;
                    end else begin
                        w_mosi_nxt     = r_tx[6];
                    end
                end
            end
            ST_HOLD: begin
                w_sclk_nxt = 1'b0;
                if (w_hold_end) begin
                    w_cs_n_nxt    = 1'b1;
                    w_dc_nxt      = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_cmd_rdy_nxt = 1'b1;
                    w_grd_cnt_nxt = '0;
                end else begin
                    w_grd_cnt_nxt = r_grd_cnt + GRD_W'(1'b1);
                end
            end
            default: begin
                w_sclk_nxt    = 1'b0;
                w_mosi_nxt    = 1'b0;
                w_cs_n_nxt    = 1'b1;
                w_dc_nxt      = 1'b0;
                w_cmd_rdy_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_dfm_spi_master.sv
// Directed bench for dfm_spi_master: a vector table of whole transactions on a
// CLK_DIV=4 and a CLK_DIV=1 instance, plus busy and mid-byte reset sequences.
module tb_dfm_spi_master;

    logic clk;
    logic rst;
    logic sclk0, mosi0, cs0, dc0, miso0;
    logic sclk1, mosi1, cs1, dc1, miso1;

    dfm_spi_master_if if0();
    dfm_spi_master_if if1();

    logic       sel;
    logic       req_vld;
    logic       req_dc;
    logic [7:0] req_data;
    logic [3:0] req_len;

    assign if0.cmd_vld_i  = req_vld & ~sel;
    assign if0.cmd_dc_i   = req_dc;
    assign if0.cmd_data_i = req_data;
    assign if0.rd_len_i   = req_len;
    assign if1.cmd_vld_i  = req_vld & sel;
    assign if1.cmd_dc_i   = req_dc;
    assign if1.cmd_data_i = req_data;
    assign if1.rd_len_i   = req_len;

    dfm_spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .host(if0),
        .spi_sclk_o(sclk0), .spi_mosi_o(mosi0), .spi_cs_n_o(cs0),
        .dc_o(dc0), .spi_miso_i(miso0)
    );

    dfm_spi_master #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .host(if1),
        .spi_sclk_o(sclk1), .spi_mosi_o(mosi1), .spi_cs_n_o(cs1),
        .dc_o(dc1), .spi_miso_i(miso1)
    );

    logic       m_cs_n, m_sclk, m_mosi, m_dc, m_rdy, m_rd_vld, m_done;
    logic [7:0] m_rd_data;
    assign m_cs_n    = sel ? cs1   : cs0;
    assign m_sclk    = sel ? sclk1 : sclk0;
    assign m_mosi    = sel ? mosi1 : mosi0;
    assign m_dc      = sel ? dc1   : dc0;
    assign m_rdy     = sel ? if1.cmd_rdy_o : if0.cmd_rdy_o;
    assign m_rd_vld  = sel ? if1.rd_vld_o  : if0.rd_vld_o;
    assign m_rd_data = sel ? if1.rd_data_o : if0.rd_data_o;
    assign m_done    = sel ? if1.done_o    : if0.done_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MISO model: byte 0 answers the command and must be discarded
    logic [7:0] miso_bytes [0:8];
    int midx0, midx1;

    function automatic logic miso_bit(input int idx);
        logic [7:0] b;
        if (idx >= 72) return 1'b0;
        b = miso_bytes[idx / 8];
        return b[7 - (idx % 8)];
    endfunction

    always @(negedge cs0) begin midx0 = 0; miso0 = miso_bit(0); end
    always @(negedge sclk0) if (cs0 === 1'b0) begin midx0 = midx0 + 1; miso0 = miso_bit(midx0); end
    always @(negedge cs1) begin midx1 = 0; miso1 = miso_bit(0); end
    always @(negedge sclk1) if (cs1 === 1'b0) begin midx1 = midx1 + 1; miso1 = miso_bit(midx1); end

    int n_pass, n_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    int         cyc, cs_low, rises, done_cnt, done_cyc, rd_last_cyc;
    int         mosi_err, dc_err, rdy_err, cur_run, max_run;
    logic [7:0] rd_q [$];
    logic       mosi_bits [$];
    logic       prev_sclk, prev_mosi, prev_cs, exp_dc;

    task automatic clear_stats();
        cyc = 0; cs_low = 0; rises = 0; done_cnt = 0; done_cyc = 0; rd_last_cyc = 0;
        mosi_err = 0; dc_err = 0; rdy_err = 0; cur_run = 0; max_run = 0;
        rd_q.delete(); mosi_bits.delete();
        prev_sclk = m_sclk; prev_mosi = m_mosi; prev_cs = m_cs_n;
    endtask

    task automatic sample_cycle();
        @(negedge clk);
        cyc++;
        if (m_cs_n === 1'b0) begin
            cs_low++;
            if (m_rdy !== 1'b0) rdy_err++;
            if (m_dc !== exp_dc) dc_err++;
        end
        if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
            rises++;
            mosi_bits.push_back(m_mosi);
        end
        if (m_mosi !== prev_mosi && !(prev_sclk === 1'b1 && m_sclk === 1'b0) && m_cs_n === prev_cs) mosi_err++;
        if (m_sclk === 1'b1) cur_run++;
        else begin
            if (cur_run > max_run) max_run = cur_run;
            cur_run = 0;
        end
        if (m_rd_vld === 1'b1) begin rd_q.push_back(m_rd_data); rd_last_cyc = cyc; end
        if (m_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        prev_sclk = m_sclk; prev_mosi = m_mosi; prev_cs = m_cs_n;
    endtask

    function automatic logic [7:0] mosi_byte0();
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) if (k < mosi_bits.size()) b = {b[6:0], mosi_bits[k]};
        return b;
    endfunction

    function automatic int mosi_tail_ones();
        int ones;
        ones = 0;
        for (int k = 8; k < mosi_bits.size(); k++) if (mosi_bits[k] !== 1'b0) ones++;
        return ones;
    endfunction

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done_cnt == 0; i++) sample_cycle();
    endtask

    typedef struct {
        logic       sel;
        logic [7:0] cmd;
        logic       dc;
        logic [3:0] len;
        logic [7:0] b1;
        int         exp_nrd;
        int         exp_cs;
        int         div;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v, input int id);
        sel = v.sel;
        miso_bytes[1] = v.b1;
        sample_cycle();
        chk($sformatf("v%0d_rdy_idle", id), m_rdy, 1);
        req_data = v.cmd; req_dc = v.dc; req_len = v.len; req_vld = 1'b1;
        clear_stats();
        exp_dc = v.dc;
        sample_cycle();
        req_vld = 1'b0;
        chk($sformatf("v%0d_cs_fall", id), m_cs_n, 0);
        chk($sformatf("v%0d_rdy_busy", id), m_rdy, 0);
        wait_done(3000);
        chk($sformatf("v%0d_done", id), done_cnt, 1);
        chk($sformatf("v%0d_cs_low", id), cs_low, v.exp_cs);
        chk($sformatf("v%0d_cs_at_done", id), m_cs_n, 1);
        chk($sformatf("v%0d_nrd", id), rd_q.size(), v.exp_nrd);
        for (int k = 0; k < v.exp_nrd && k < rd_q.size(); k++)
            chk($sformatf("v%0d_rd%0d", id, k), rd_q[k], miso_bytes[k + 1]);
        chk($sformatf("v%0d_nbits", id), mosi_bits.size(), 8 * (1 + v.exp_nrd));
        chk($sformatf("v%0d_mosi_cmd", id), mosi_byte0(), v.cmd);
        chk($sformatf("v%0d_mosi_zero", id), mosi_tail_ones(), 0);
        chk($sformatf("v%0d_mosi_edge", id), mosi_err, 0);
        chk($sformatf("v%0d_dc_stable", id), dc_err, 0);
        chk($sformatf("v%0d_rdy_low", id), rdy_err, 0);
        chk($sformatf("v%0d_sclk_high", id), max_run, v.div);
        if (v.exp_nrd > 0) chk($sformatf("v%0d_vld_done_gap", id), done_cyc - rd_last_cyc, v.div + 2);
        sample_cycle();
        chk($sformatf("v%0d_done_pulse", id), done_cnt, 1);
        chk($sformatf("v%0d_rdy_after", id), m_rdy, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_chk = 0;
        sel = 1'b0; req_vld = 1'b0; req_dc = 1'b0; req_data = 8'h00; req_len = 4'd0;
        miso0 = 1'b0; miso1 = 1'b0; midx0 = 0; midx1 = 0; exp_dc = 1'b0;
        miso_bytes[0] = 8'hC3;
        for (int k = 1; k <= 8; k++) miso_bytes[k] = 8'(k * 17);
        //               sel   cmd    dc    len    b1     nrd cs   div
        vecs[0] = '{1'b0, 8'h2A, 1'b1, 4'd0,  8'h11, 0, 68,  4};
        vecs[1] = '{1'b0, 8'h01, 1'b0, 4'd8,  8'h11, 8, 580, 4};
        vecs[2] = '{1'b0, 8'h5C, 1'b1, 4'd15, 8'h11, 8, 580, 4};
        vecs[3] = '{1'b0, 8'h80, 1'b0, 4'd3,  8'h11, 3, 260, 4};
        vecs[4] = '{1'b1, 8'h96, 1'b1, 4'd1,  8'hA5, 1, 36,  1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", m_cs_n, 1);
        chk("rst_sclk", m_sclk, 0);
        chk("rst_mosi", m_mosi, 0);
        chk("rst_dc", m_dc, 0);
        chk("rst_rdy", m_rdy, 1);
        chk("rst_rd_vld", m_rd_vld, 0);
        chk("rst_rd_data", m_rd_data, 0);
        chk("rst_done", m_done, 0);
        chk("rst_cs1", cs1, 1);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

        // Busy: request held high, data changed mid-transaction
        sel = 1'b0;
        miso_bytes[1] = 8'h11;
        sample_cycle();
        req_data = 8'h33; req_dc = 1'b1; req_len = 4'd0; req_vld = 1'b1;
        clear_stats();
        exp_dc = 1'b1;
        sample_cycle();
        req_data = 8'h4D; req_dc = 1'b0;
        wait_done(3000);
        chk("busy_done1", done_cnt, 1);
        chk("busy_rdy_low", rdy_err, 0);
        chk("busy_cs_low1", cs_low, 68);
        chk("busy_cmd1", mosi_byte0(), 8'h33);
        chk("busy_dc1", dc_err, 0);
        chk("busy_cs_gap", m_cs_n, 1);
        clear_stats();
        exp_dc = 1'b0;
        sample_cycle();
        req_vld = 1'b0;
        chk("busy_restart_cs", m_cs_n, 0);
        chk("busy_restart_rdy", m_rdy, 0);
        wait_done(3000);
        chk("busy_done2", done_cnt, 1);
        chk("busy_cs_low2", cs_low, 68);
        chk("busy_cmd2", mosi_byte0(), 8'h4D);
        chk("busy_dc2", dc_err, 0);

        // Reset at the 3rd SCLK rise of read byte 2
        sample_cycle();
        req_data = 8'h01; req_dc = 1'b0; req_len = 4'd8; req_vld = 1'b1;
        clear_stats();
        exp_dc = 1'b0;
        sample_cycle();
        req_vld = 1'b0;
        for (int i = 0; i < 3000 && rises < 19; i++) sample_cycle();
        chk("rstm_rises", rises, 19);
        chk("rstm_nrd", rd_q.size(), 1);
        if (rd_q.size() > 0) chk("rstm_rd0", rd_q[0], 8'h11);
        rst = 1'b1;
        sample_cycle();
        rst = 1'b0;
        chk("rstm_cs_n", m_cs_n, 1);
        chk("rstm_sclk", m_sclk, 0);
        chk("rstm_rdy", m_rdy, 1);
        chk("rstm_mosi", m_mosi, 0);
        chk("rstm_dc", m_dc, 0);
        chk("rstm_rd_vld", m_rd_vld, 0);
        clear_stats();
        for (int i = 0; i < 700; i++) sample_cycle();
        chk("rstm_no_vld", rd_q.size(), 0);
        chk("rstm_no_done", done_cnt, 0);
        chk("rstm_cs_idle", cs_low, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
